// File: rtl/bcd_conv_arbiter.sv
// Iterative double-dabble binary-to-BCD converter shared by two round-robin requesters.
// Optional BCD_OVF_SAT_EN: saturate to all-nines and flag out_ovf when input exceeds range.
module bcd_conv_arbiter #(
   parameter int unsigned BIN_W  = 14,
   parameter int unsigned DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req0_valid,
   output logic                  req0_ready,
   input  logic [BIN_W-1:0]      req0_bin,
   input  logic                  req1_valid,
   output logic                  req1_ready,
   input  logic [BIN_W-1:0]      req1_bin,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   out_bcd,
   output logic                  out_id,
   output logic                  out_ovf,
   output logic                  busy
);

   localparam int unsigned BCD_W = 4 * DIGITS;
   localparam int unsigned CNT_W = $clog2(BIN_W + 1);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e             state_q, state_d;
   logic               rr_q, rr_d;
   logic [BIN_W-1:0]   bin_q, bin_d;
   logic [BCD_W-1:0]   bcd_q, bcd_d, bcd_adj;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               id_q, id_d;
   logic               grant, accept, idle_ok;
   logic [BIN_W-1:0]   sel_bin;

`ifdef BCD_OVF_SAT_EN
   function automatic int unsigned pow10(input int unsigned n);
      int unsigned r;
      r = 1;
      for (int unsigned i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction

   localparam logic [31:0] BCD_MAX = 32'(pow10(DIGITS) - 1);

   logic ovf_q, ovf_d;
`endif

   // rr_q high means requester 1 is favoured on a tie
   assign grant      = req1_valid & (~req0_valid | rr_q);
   assign idle_ok    = (state_q == StIdle) & ~rst;
   assign req0_ready = idle_ok & req0_valid & ~grant;
   assign req1_ready = idle_ok & req1_valid & grant;
   assign accept     = req0_ready | req1_ready;
   assign sel_bin    = grant ? req1_bin : req0_bin;

   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
   end

   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      id_d    = id_q;
`ifdef BCD_OVF_SAT_EN
      ovf_d   = ovf_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               bin_d   = sel_bin;
               bcd_d   = '0;
               cnt_d   = CNT_W'(BIN_W);
               id_d    = grant;
               rr_d    = ~grant;
`ifdef BCD_OVF_SAT_EN
               ovf_d   = (32'(sel_bin) > BCD_MAX);
`endif
               state_d = StShift;
            end
         end
         StShift: begin
            // high bits leaving the top digit are intentionally dropped
            bcd_d = {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
            bin_d = {bin_q[BIN_W-2:0], 1'b0};
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = StDone;
         end
         StDone: begin
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         rr_q    <= 1'b0;
         bin_q   <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         id_q    <= 1'b0;
`ifdef BCD_OVF_SAT_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
         id_q    <= id_d;
`ifdef BCD_OVF_SAT_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign out_valid = (state_q == StDone) & ~rst;
   assign busy      = (state_q != StIdle) & ~rst;
   assign out_id    = id_q;

`ifdef BCD_OVF_SAT_EN
   assign out_bcd = ovf_q ? {DIGITS{4'h9}} : bcd_q;
   assign out_ovf = ovf_q;
`else
   assign out_bcd = bcd_q;
   assign out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Bench for bcd_conv_arbiter: directed scenarios plus random traffic against a
// transaction-level model (arithmetic BCD, round-robin grant, fixed latency).
module tb_bcd_conv_arbiter;

   localparam int unsigned BIN_W  = 14;
   localparam int unsigned DIGITS = 4;

`ifdef BCD_OVF_SAT_EN
   localparam bit OvfEn = 1'b1;
`else
   localparam bit OvfEn = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              req0_valid, req0_ready, req1_valid, req1_ready;
   logic [BIN_W-1:0]  req0_bin, req1_bin;
   logic              out_valid, out_ready, out_id, out_ovf, busy;
   logic [15:0]       out_bcd;

   always #5 clk = ~clk;

   bcd_conv_arbiter #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_bin   (req0_bin),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_bin   (req1_bin),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_bcd    (out_bcd),
      .out_id     (out_id),
      .out_ovf    (out_ovf),
      .busy       (busy)
   );

   int unsigned n_chk = 0;
   int unsigned n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] to_bcd(input int unsigned v);
      int unsigned x;
      logic [15:0] r;
      if (OvfEn && v > 9999) return 16'h9999;
      x = v % 10000;
      r = '0;
      for (int i = 0; i < 4; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   // Transaction-level model: 0 idle, 1 converting, 2 result pending
   int          m_phase = 0;
   int          m_left  = 0;
   bit          m_pref  = 1'b0;
   bit          m_id    = 1'b0;
   bit          m_ovf   = 1'b0;
   bit          m_rstflag = 1'b0;
   logic [15:0] m_exp   = '0;
   bit          dut_ids[$];

   task automatic step();
      bit e0, e1, v0, v1, orr, r;
      int unsigned b0, b1;
      #1;
      r   = rst;
      v0  = req0_valid;
      v1  = req1_valid;
      b0  = req0_bin;
      b1  = req1_bin;
      orr = out_ready;
      e0  = !r && m_phase == 0 && v0 && (!v1 || m_pref == 1'b0);
      e1  = !r && m_phase == 0 && v1 && (!v0 || m_pref == 1'b1);
      check("req0_ready", req0_ready, e0);
      check("req1_ready", req1_ready, e1);
      check("out_valid", out_valid, !r && m_phase == 2);
      check("busy", busy, !r && m_phase != 0);
      if (!r && m_phase == 2) begin
         check("out_bcd", out_bcd, m_exp);
         check("out_id", out_id, m_id);
         check("out_ovf", out_ovf, m_ovf);
         if (orr && out_valid) dut_ids.push_back(out_id);
      end
      if (m_rstflag) begin
         check("rst_bcd", out_bcd, 0);
         check("rst_id", out_id, 0);
         check("rst_ovf", out_ovf, 0);
         m_rstflag = 1'b0;
      end
      @(posedge clk);
      if (r) begin
         m_phase   = 0;
         m_pref    = 1'b0;
         m_rstflag = 1'b1;
      end else begin
         case (m_phase)
            0: if (e0 || e1) begin
               m_id    = e1;
               m_exp   = to_bcd(e1 ? b1 : b0);
               m_ovf   = OvfEn && ((e1 ? b1 : b0) > 9999);
               m_pref  = !e1;
               m_left  = BIN_W;
               m_phase = 1;
            end
            1: begin
               m_left--;
               if (m_left == 0) m_phase = 2;
            end
            default: if (orr) m_phase = 0;
         endcase
      end
      @(negedge clk);
   endtask

   task automatic settle();
      int n;
      n = 0;
      while (m_phase != 0 && n < 200) begin
         step();
         n++;
      end
      if (m_phase != 0) check("settle_timeout", 1, 0);
      step();
   endtask

   function automatic logic [BIN_W-1:0] pick();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return BIN_W'(9999);
         2:       return BIN_W'(16383);
         3:       return BIN_W'(10000);
         default: return BIN_W'($urandom_range(0, 16383));
      endcase
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
      req0_bin = '0; req1_bin = '0; out_ready = 1'b1;
      @(negedge clk);
      repeat (3) step();
      rst = 1'b0;

      // single requester, value 1234
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_valid = 1'b1; req0_bin = BIN_W'(1234);
      step();
      req0_valid = 1'b0; req0_bin = '0;
      settle();

      // both requesters held from reset: grants must alternate 0,1,0,1
      rst = 1'b1; step(); rst = 1'b0;
      dut_ids.delete();
      req0_valid = 1'b1; req0_bin = BIN_W'(42);
      req1_valid = 1'b1; req1_bin = BIN_W'(9999);
      repeat (4 * (BIN_W + 2) + 2) step();
      req0_valid = 1'b0; req1_valid = 1'b0;
      settle();
      check("alt_count", dut_ids.size() >= 4, 1);
      for (int k = 0; k < 4 && k < dut_ids.size(); k++) check("alt_order", dut_ids[k], k % 2);

      // zero and all-nines
      req1_valid = 1'b1; req1_bin = '0; step(); req1_valid = 1'b0; settle();
      req0_valid = 1'b1; req0_bin = BIN_W'(9999); step(); req0_valid = 1'b0; settle();

      // downstream stall; late input changes and a waiting requester must be ignored
      out_ready = 1'b0;
      req0_valid = 1'b1; req0_bin = BIN_W'(2468); step();
      req0_valid = 1'b0; req0_bin = BIN_W'(16383);
      req1_valid = 1'b1; req1_bin = BIN_W'(5);
      repeat (BIN_W + 21) step();
      out_ready = 1'b1; step();
      req1_valid = 1'b0; settle();

      // out-of-range input
      req0_valid = 1'b1; req0_bin = BIN_W'(16383); step(); req0_valid = 1'b0; settle();

      // reset in the middle of a conversion, then a fresh request
      req0_valid = 1'b1; req0_bin = BIN_W'(5678); step(); req0_valid = 1'b0;
      repeat (7) step();
      rst = 1'b1; step(); rst = 1'b0;
      req0_valid = 1'b1; req0_bin = BIN_W'(321); step(); req0_valid = 1'b0;
      settle();

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         rst        = ($urandom_range(0, 299) == 0);
         req0_valid = ($urandom_range(0, 2) != 0);
         req1_valid = ($urandom_range(0, 2) != 0);
         req0_bin   = pick();
         req1_bin   = pick();
         out_ready  = ($urandom_range(0, 3) != 0);
         step();
      end
      rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b1;
      settle();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/bcd_conv_arbiter.md
# bcd_conv_arbiter

Sequential double-dabble binary-to-BCD engine shared between two requesters under round-robin arbitration. Each requester hands over a 14-bit binary value on a valid/ready handshake; the block converts it one bit per clock and returns four packed BCD digits tagged with the requester ID. It sits between producers (counter/display logic) and the 7-segment/UART formatting stage, replacing per-requester combinational converters with one iterative datapath.

## Interface
- BIN_W, 14: binary input width; shift-cycle count equals BIN_W.
- DIGITS, 4: BCD digits produced; output width 4*DIGITS.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has a value to convert.
- req0_ready  output  1  requester 0 accepted this cycle when high with req0_valid.
- req0_bin  input  BIN_W  requester 0 binary value.
- req1_valid  input  1  requester 1 has a value to convert.
- req1_ready  output  1  requester 1 accepted this cycle when high with req1_valid.
- req1_bin  input  BIN_W  requester 1 binary value.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts result.
- out_bcd  output  4*DIGITS  packed BCD, digit 0 in [3:0].
- out_id  output  1  requester that owns out_bcd.
- out_ovf  output  1  input exceeded 10^DIGITS-1 (see Configuration).
- busy  output  1  high in any state other than IDLE.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: grant computed combinationally; only the granted requester's ready is high; the other's ready is low. No valid requests -> no ready.
- Arbitration: single valid request wins. Both valid -> requester not served last wins; rr pointer updates on each accept. After reset, pointer favours requester 0.
- Accept (valid & ready at edge): capture bin into shift register, clear BCD accumulator, load counter = BIN_W, latch ID, go SHIFT.
- SHIFT, each cycle: every digit >= 5 gets +3 (4-bit, no carry across digits), then {bcd, bin} shifted left one bit, MSB of bin enters bcd[0]; counter decrements. Bits shifted out of bcd MSB are discarded.
- After the BIN_W-th shift -> DONE.
- DONE: out_valid high; out_bcd, out_id, out_ovf held stable until out_valid & out_ready at an edge, then IDLE. No request accepted while in SHIFT or DONE.
- Reset: state IDLE, rr pointer to 0, accumulator 0, counter 0; outputs out_valid=0, out_bcd=0, out_id=0, out_ovf=0, busy=0, req0_ready/req1_ready=0 while rst high.
- Reset mid-SHIFT or in DONE: conversion discarded, no out_valid emitted, next accept allowed the cycle after rst deasserts.

## Timing
- Accept at edge E0 -> out_valid high in the cycle after edge E0+BIN_W (14 cycles for default).
- out_ready held high -> result transfers on first DONE edge; IDLE next cycle; earliest next accept one cycle later. Peak throughput: one conversion per BIN_W+2 cycles.
- out_ready low: DONE held indefinitely, both ready outputs low, requester inputs ignored.
- Requester inputs sampled only on the accept edge; changes afterwards have no effect.
- busy rises the cycle after accept, falls the cycle after output transfer.

## Configuration
- BCD_OVF_SAT_EN defined: input compared against 10^DIGITS-1 at accept; if greater, out_bcd = all digits 9 (16'h9999 default) and out_ovf=1; latency unchanged.
- Not defined: out_ovf tied 0; out_bcd = value mod 10^DIGITS in BCD (truncated high digits).

## Test plan
- req0 bin=1234 alone, out_ready=1 -> req0_ready on accept edge, out_valid exactly 14 cycles later, out_bcd=16'h1234, out_id=0, busy low two cycles after.
- req0=0042 and req1=9999 asserted same cycle from reset -> req0 served first (16'h0042, id 0), then req1 (16'h9999, id 1); repeat with both held -> grants alternate 0,1,0,1.
- bin=0 and bin=9999 -> 16'h0000 and 16'h9999, out_ovf=0.
- out_ready low 20 cycles after DONE -> out_valid, out_bcd, out_id stable; req1_valid high throughout gets no ready until transfer.
- bin=16383: with BCD_OVF_SAT_EN -> 16'h9999, out_ovf=1; without -> 16'h6383, out_ovf=0.
- rst pulsed at shift 7 of bin=5678 -> no out_valid, all outputs 0; new request bin=0321 after reset -> 16'h0321 at normal latency.
